wb_keystream_reader: RTL and testbench
======================================

Name: wb_keystream_reader

Overview:
- Wishbone classic initiator that fetches keystream words from the keystream generator's Wishbone responder.
- The responder serves its FIFO at address 0.
- Issues single non-pipelined reads, one at a time, to a fixed address and forwards each returned word on a valid/ready stream to a downstream consumer (cipher XOR datapath).
- A run is a programmed word count; a per-transaction ack timeout guards against a hung responder.

Parameters:
- RD_ADDR, 32'h0000_0000, Wishbone address driven on every read.
- TIMEOUT, 255, cycles allowed from stb assertion to ack before abandoning the transaction (1..65535).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a run, ignored while busy=1
- word_count  in  16  words to fetch, sampled on accepted start
- abort  in  1  synchronous cancel of current run
- busy  out  1  run in progress
- done  out  1  single-cycle pulse at run completion (normal, zero-count or timeout)
- timeout_err  out  1  sticky; set on timeout, cleared on next accepted start
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe, always equal to wbm_cyc_o
- wbm_we_o  out  1  constant 0
- wbm_sel_o  out  4  constant 4'hF
- wbm_adr_o  out  32  RD_ADDR while cyc=1, else 0
- wbm_dat_o  out  32  constant 0
- wbm_ack_i  in  1  responder ack
- wbm_dat_i  in  32  read data, valid with ack
- m_valid  out  1  output word available
- m_data  out  32  output word, stable while m_valid=1 and m_ready=0
- m_ready  in  1  consumer accepts when m_valid & m_ready

Behaviour:
- All outputs are registered.
- Reset values:
  - busy=0, done=0, timeout_err=0
  - cyc=stb=0, adr=0
  - m_valid=0, m_data=0
  - state=IDLE, remaining=0, timer=0
- States: IDLE, REQ, OUT.
- IDLE:
  - start=1, word_count!=0: latch remaining=word_count, clear timeout_err, busy=1, go REQ; cyc/stb rise the following cycle.
  - start=1, word_count=0: clear timeout_err, done=1 next cycle, stay IDLE, busy stays 0.
  - wbm_ack_i is ignored in IDLE.
- REQ:
  - cyc=stb=1, timer increments each cycle.
  - On ack: capture wbm_dat_i into m_data, drop cyc/stb next cycle, m_valid=1 next cycle, go OUT.
  - Ack in the first REQ cycle is legal; minimum latency ack→m_valid is 1 cycle.
  - Timer reaches TIMEOUT with no ack: drop cyc/stb, set timeout_err, done=1, busy=0, go IDLE.
  - Ack and timer expiry in the same cycle: ack wins.
- OUT:
  - m_valid=1; on m_valid & m_ready, m_valid drops next cycle and remaining decrements.
  - remaining was 1: done=1, busy=0, go IDLE.
  - Otherwise: timer=0, go REQ.
- cyc/stb are low for at least one cycle between consecutive transactions; never assert stb while ack is still high from the previous transfer.
- abort:
  - Any state: next cycle cyc=stb=0, m_valid=0, busy=0, state=IDLE.
  - No done pulse; timeout_err unchanged.
  - abort takes priority over start and ack in the same cycle.
- remaining is a 16-bit counter; word_count=16'hFFFF performs 65535 reads with no wrap.
- Asynchronous reset mid-transaction drops cyc/stb immediately; a returning ack after reset is ignored.
- Read data is forwarded unchanged, including the responder's data when its FIFO was empty.

Test Plan:
- Reset, then start with word_count=3; responder acks 1 cycle after stb with 32'hA5A5_0001/2/3; m_ready=1 → exactly 3 bus reads at adr 0 with we=0 and sel=F, m_data sequence 1,2,3, one done pulse, busy low after.
- word_count=2, m_ready held 0 for 10 cycles after first m_valid → m_valid and m_data held stable, no second stb until the handshake, then second read completes, done pulse.
- TIMEOUT=8, responder never acks → stb high exactly 8 cycles, then cyc/stb=0, timeout_err=1, done pulse; next start with word_count=1 clears timeout_err.
- start with word_count=0 → done pulse the next cycle, no cyc, busy stays 0.
- abort asserted while stb=1, then a stray ack 2 cycles later → cyc=0 next cycle, no done, m_valid stays 0, stray ack ignored.
- start pulsed while busy, plus back-to-back acks from an always-ack responder → second start ignored, ≥1 idle cyc cycle between every transaction, word count honoured.

Source files
------------

// File: rtl/wb_keystream_reader.sv
// Wishbone classic read initiator: fetches keystream words from a fixed address one at a time
// and forwards each word on a valid/ready stream, with a per-transfer ack timeout.
module wb_keystream_reader #(
    parameter logic [31:0] RD_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;

    // Timer counts stb cycles from 0, so expiry is detected on the last allowed cycle.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] timer_q, timer_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        terr_q, terr_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        terr_d      = terr_q;
        cyc_d       = cyc_q;
        valid_d     = valid_q;
        data_d      = data_q;

        if (abort) begin
            state_d = StIdle;
            cyc_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            timer_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        terr_d = 1'b0;
                        if (word_count != 16'd0) begin
                            remaining_d = word_count;
                            timer_d     = '0;
                            busy_d      = 1'b1;
                            cyc_d       = 1'b1;
                            state_d     = StReq;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StReq: begin
                    // A same-cycle ack beats timer expiry.
                    if (wbm_ack_i) begin
                        data_d  = wbm_dat_i;
                        valid_d = 1'b1;
                        cyc_d   = 1'b0;
                        state_d = StOut;
                    end else if (timer_q == TimeoutLast) begin
                        cyc_d   = 1'b0;
                        terr_d  = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        timer_d = '0;
                        state_d = StIdle;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                StOut: begin
                    if (m_ready) begin
                        valid_d     = 1'b0;
                        remaining_d = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            timer_d = '0;
                            cyc_d   = 1'b1;
                            state_d = StReq;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cyc_d   = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            terr_q      <= terr_d;
            cyc_q       <= cyc_d;
            adr_q       <= cyc_d ? RD_ADDR : 32'h0000_0000;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = 4'hF;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = 32'h0000_0000;
    assign m_valid     = valid_q;
    assign m_data      = data_q;

endmodule

// File: tb/tb_wb_keystream_reader.sv
// Self-checking bench for wb_keystream_reader: scenario table, corner-case sequences and
// randomized runs against a transaction-level responder/consumer model.
module tb_wb_keystream_reader;

    localparam int unsigned TimeoutCycles = 8;
    localparam logic [31:0] RdAddr = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_count = 16'd0;
    logic        abort = 1'b0;
    logic        busy, done, timeout_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;

    wb_keystream_reader #(
        .RD_ADDR(RdAddr),
        .TIMEOUT(TimeoutCycles)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_dat_i  (wbm_dat_i),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Responder model: registered ack after resp_delay wait cycles, combinational ack, or none.
    int          resp_delay = 0;
    bit          resp_never = 1'b0;
    bit          resp_comb = 1'b0;
    bit          manual_ack = 1'b0;
    bit          seq_mode = 1'b0;
    int          seq_base = 0;
    int          ack_total = 0;
    int          wait_cnt = 0;
    logic        ack_q = 1'b0;
    logic [31:0] rnd_word = 32'h1234_5678;
    logic [31:0] cur_word;
    logic [31:0] exp_q[$];

    assign cur_word  = seq_mode ? 32'hA5A5_0001 + 32'(ack_total - seq_base) : rnd_word;
    assign wbm_dat_i = cur_word;
    assign wbm_ack_i = manual_ack | (!resp_never & (resp_comb ? wbm_stb_o : ack_q));

    always @(posedge clk) begin
        // Every ack seen with stb high (and no abort) delivers one word downstream, in order.
        if (reset_n && wbm_stb_o && wbm_ack_i && !abort) begin
            exp_q.push_back(cur_word);
            ack_total <= ack_total + 1;
            rnd_word  <= $urandom;
        end
        if (wbm_stb_o && !ack_q && !resp_never && !resp_comb) begin
            if (wait_cnt >= resp_delay) begin
                ack_q    <= 1'b1;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            ack_q <= 1'b0;
            if (!wbm_stb_o) wait_cnt <= 0;
        end
    end

    bit rdy_rand = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
    end

    // Bus/stream monitor and scoreboard, sampled on the falling edge.
    int          done_cnt = 0, stb_rises = 0, words_out = 0, stb_run = 0, last_run = 0;
    logic        prev_stb = 0, prev_ack = 0, prev_stb_ack = 0, prev_done = 0;
    logic        prev_valid = 0, prev_ready = 0, prev_abort = 0;
    logic [31:0] prev_data = 0;

    always @(negedge clk) begin
        check("bus_fields", {wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
              {wbm_cyc_o, 1'b0, 4'hF, wbm_cyc_o ? RdAddr : 32'h0, 32'h0});
        if (reset_n) begin
            if (done) begin
                done_cnt++;
                check("done_single_cycle", prev_done, 1'b0);
            end
            if (wbm_stb_o && !prev_stb) begin
                stb_rises++;
                check("stb_rise_with_ack_high", prev_ack, 1'b0);
            end
            if (prev_stb_ack) check("idle_gap_after_ack", wbm_stb_o, 1'b0);
            if (wbm_stb_o) stb_run++;
            else if (prev_stb) begin
                last_run = stb_run;
                stb_run  = 0;
            end
            if (prev_valid && !prev_ready && !prev_abort)
                check("m_hold_stable", {m_valid, m_data}, {1'b1, prev_data});
            if (m_valid && m_ready) begin
                words_out++;
                check("sb_word_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("sb_data", m_data, exp_q.pop_front());
            end
            prev_stb     = wbm_stb_o;
            prev_ack     = wbm_ack_i;
            prev_stb_ack = wbm_stb_o & wbm_ack_i;
            prev_done    = done;
            prev_valid   = m_valid;
            prev_ready   = m_ready;
            prev_abort   = abort;
            prev_data    = m_data;
        end else begin
            prev_stb = 0; prev_ack = 0; prev_stb_ack = 0; prev_done = 0;
            prev_valid = 0; prev_ready = 0; prev_abort = 0; stb_run = 0;
        end
    end

    task automatic pulse_start(input logic [15:0] wc);
        @(posedge clk); #1;
        word_count = wc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int done0);
        bit seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done_cnt != done0) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic run_scn(input string tag, input logic [15:0] wc, input int delay,
                           input bit never, input bit comb, input bit rrand,
                           input int exp_reads, input int exp_words, input bit exp_terr);
        int rises0, words0, done0;
        @(posedge clk); #1;
        resp_delay = delay;
        resp_never = never;
        resp_comb  = comb;
        rdy_rand   = rrand;
        if (!rrand) m_ready = 1'b1;
        rises0 = stb_rises;
        words0 = words_out;
        done0  = done_cnt;
        pulse_start(wc);
        check({tag, "_terr_cleared"}, timeout_err, 1'b0);
        wait_done(tag, done0);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - done0, 1);
        check({tag, "_reads"}, stb_rises - rises0, exp_reads);
        check({tag, "_words"}, words_out - words0, exp_words);
        check({tag, "_idle_flags"}, {timeout_err, busy, m_valid, wbm_cyc_o},
              {exp_terr, 3'b000});
        check({tag, "_sb_drained"}, exp_q.size(), 0);
        if (never) check({tag, "_stb_cycles"}, last_run, TimeoutCycles);
    endtask

    typedef struct {
        logic [15:0] wc;
        int          delay;
        bit          never;
        bit          comb;
        bit          rrand;
        bit          seq;
        int          reads;
        int          words;
        bit          terr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int rises0, done0;
        bit seen;
        logic [31:0] d0;

        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
        $fatal(1);
    end

    initial begin
        int rises0, words0, done0;
        bit seen;
        logic [31:0] d0;

        tbl[0] = '{16'd3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0};  // A5A5_0001..3, ready=1
        tbl[1] = '{16'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};  // zero count
        tbl[2] = '{16'd2, 3, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 1'b0};
        tbl[3] = '{16'd4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1};  // hung responder
        tbl[4] = '{16'd1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0};  // clears timeout_err
        tbl[5] = '{16'd5, 0, 1'b0, 1'b1, 1'b1, 1'b0, 5, 5, 1'b0};  // first-cycle acks
        tbl[6] = '{16'd4, 6, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy, done, timeout_err, wbm_cyc_o, wbm_stb_o, m_valid, m_data,
              wbm_adr_o}, '0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {busy, done, wbm_cyc_o, m_valid}, 4'b0000);

        foreach (tbl[i]) begin
            seq_base = ack_total;
            seq_mode = tbl[i].seq;
            run_scn($sformatf("tbl%0d", i), tbl[i].wc, tbl[i].delay, tbl[i].never,
                    tbl[i].comb, tbl[i].rrand, tbl[i].reads, tbl[i].words, tbl[i].terr);
        end
        seq_mode = 1'b0;

        // Zero count: done exactly on the cycle after start, no bus activity.
        pulse_start(16'd0);
        @(negedge clk);
        check("zero_done_next", {done, busy, wbm_cyc_o}, 3'b100);
        @(negedge clk);
        check("zero_done_drop", {done, busy, wbm_cyc_o}, 3'b000);

        // Consumer stall: first word held, no second read until the handshake.
        @(posedge clk); #1;
        resp_never = 0; resp_comb = 0; resp_delay = 0; rdy_rand = 0; m_ready = 1'b0;
        rises0 = stb_rises; words0 = words_out; done0 = done_cnt;
        pulse_start(16'd2);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        check("stall_valid_seen", seen, 1'b1);
        d0 = m_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {m_valid, m_data, wbm_stb_o}, {1'b1, d0, 1'b0});
        end
        check("stall_one_read", stb_rises - rises0, 1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_done("stall", done0);
        repeat (2) @(negedge clk);
        check("stall_reads", stb_rises - rises0, 2);
        check("stall_words", words_out - words0, 2);

        // Abort during a strobe, then a stray ack.
        @(posedge clk); #1;
        resp_never = 1'b1;
        done0 = done_cnt; words0 = words_out;
        pulse_start(16'd3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wbm_stb_o) seen = 1'b1;
        end
        check("abort_stb_seen", seen, 1'b1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_drop", {wbm_cyc_o, wbm_stb_o, busy, m_valid}, 4'b0000);
        @(posedge clk); #1;
        manual_ack = 1'b1;
        @(posedge clk); #1;
        manual_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt - done0, 0);
        check("abort_stray_ignored", {m_valid, busy, wbm_cyc_o, timeout_err}, 4'b0000);
        check("abort_no_words", words_out - words0, 0);

        // Start while busy is ignored; always-ack responder, back-to-back transfers.
        @(posedge clk); #1;
        resp_never = 1'b0; resp_comb = 1'b1; m_ready = 1'b1;
        rises0 = stb_rises; words0 = words_out; done0 = done_cnt;
        pulse_start(16'd4);
        @(negedge clk);
        check("busy_during_run", busy, 1'b1);
        pulse_start(16'd9);
        wait_done("busy_start", done0);
        repeat (6) @(negedge clk);
        check("busy_start_reads", stb_rises - rises0, 4);
        check("busy_start_words", words_out - words0, 4);
        check("busy_start_done", done_cnt - done0, 1);
        check("busy_start_idle", {busy, wbm_cyc_o}, 2'b00);

        // Asynchronous reset mid-transaction, then a late ack.
        @(posedge clk); #1;
        resp_comb = 1'b0; resp_never = 1'b1;
        done0 = done_cnt;
        pulse_start(16'd2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (wbm_stb_o) seen = 1'b1;
        end
        check("rst_stb_seen", seen, 1'b1);
        #2 reset_n = 1'b0;
        #1 check("async_rst_drop", {wbm_cyc_o, wbm_stb_o, busy, m_valid}, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        manual_ack = 1'b1;
        @(posedge clk); #1;
        manual_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_late_ack", {busy, m_valid, wbm_cyc_o, timeout_err, m_data}, '0);
        check("rst_no_done", done_cnt - done0, 0);

        // Randomized runs against the transaction-level expectations.
        for (int k = 0; k < 24; k++) begin
            int rwc, rdl;
            bit rnv, rcb;
            rwc = $urandom_range(1, 6);
            rdl = $urandom_range(0, 3);
            rcb = 1'($urandom_range(0, 1));
            rnv = ($urandom_range(0, 7) == 0);
            run_scn($sformatf("rnd%0d", k), 16'(rwc), rdl, rnv, rcb, 1'b1,
                    rnv ? 1 : rwc, rnv ? 0 : rwc, rnv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
